// File: rtl/dma_arb_pkg.sv
// Shared types and default widths for the DMA read arbiter.
package dma_arb_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/dma_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches the pending mask starting one
// position past the previous owner and returns the first requester found.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);
  import dma_arb_pkg::*;

  int idx;

  // Walk the requesters in rotating order and keep the first pending one.
  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_valid && pending[idx]) begin
        grant_id    = ID_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_read_arbiter.sv
// Shares one DMA burst-read port between several requesters. Requests are
// latched per requester, granted round-robin, and the burst address is held
// until the next grant. Read data is routed only to the current owner.
module dma_read_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = dma_arb_pkg::ADDR_W,
  parameter  int DATA_W  = dma_arb_pkg::DATA_W,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_RD_ADDR,
  input  logic [NUM_REQ-1:0]        REQ_START,
  output logic [NUM_REQ-1:0]        REQ_READY,
  output logic [DATA_W-1:0]         REQ_RD_DATA,
  output logic [NUM_REQ-1:0]        REQ_RD_DATA_VALID,
  output logic [ADDR_W-1:0]         DMA_RD_ADDR,
  output logic                      DMA_START,
  input  logic                      DMA_READY,
  input  logic [DATA_W-1:0]         DMA_RD_DATA,
  input  logic                      DMA_RD_DATA_VALID,
  output logic [ID_W-1:0]           GRANT_ID,
  output logic                      ARB_BUSY
);
  import dma_arb_pkg::*;

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [ADDR_W-1:0]    pend_addr_q [NUM_REQ];
  logic [ADDR_W-1:0]    pend_addr_d [NUM_REQ];
  logic [ADDR_W-1:0]    dma_addr_q, dma_addr_d;
  logic                 dma_start_q, dma_start_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_valid;
  logic                 in_burst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pending     (pending_q),
    .last_grant  (grant_q),
    .grant_id    (pick_id),
    .grant_valid (pick_valid)
  );

  // Request latching plus the grant/burst-tracking state machine.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    req_ready_d = req_ready_q;
    pend_addr_d = pend_addr_q;
    dma_addr_d  = dma_addr_q;
    dma_start_d = dma_start_q;
    grant_d     = grant_q;
    busy_d      = busy_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (REQ_START[i] && req_ready_q[i]) begin
        pending_d[i]   = 1'b1;
        pend_addr_d[i] = REQ_RD_ADDR[i*ADDR_W +: ADDR_W];
        req_ready_d[i] = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (pick_valid && DMA_READY) begin
          grant_d     = pick_id;
          dma_addr_d  = pend_addr_q[pick_id];
          dma_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        dma_start_d = 1'b0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (!DMA_READY) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (DMA_READY) begin
          pending_d[grant_q]   = 1'b0;
          req_ready_d[grant_q] = 1'b1;
          busy_d               = 1'b0;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any burst in flight immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      req_ready_q <= '1;
      dma_addr_q  <= '0;
      dma_start_q <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_ready_q <= req_ready_d;
      pend_addr_q <= pend_addr_d;
      dma_addr_q  <= dma_addr_d;
      dma_start_q <= dma_start_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  assign in_burst = (state_q == WAIT) || (state_q == BUSY);

  // Zero-latency data steering: strobes reach only the owner and only once the burst has started.
  always_comb begin
    REQ_RD_DATA_VALID = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      REQ_RD_DATA_VALID[i] = DMA_RD_DATA_VALID && in_burst && (grant_q == ID_W'(i));
    end
  end

  assign REQ_RD_DATA = DMA_RD_DATA;
  assign REQ_READY   = req_ready_q;
  assign DMA_RD_ADDR = dma_addr_q;
  assign DMA_START   = dma_start_q;
  assign GRANT_ID    = grant_q;
  assign ARB_BUSY    = busy_q;

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Bench for dma_read_arbiter: a burst-level reference model checked every
// cycle, a simple DMA engine responder, and directed scenarios with literal
// expectations.
module tb_dma_read_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_start;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [ADDR_W-1:0]         dma_addr;
  logic                      dma_start;
  logic                      dma_ready;
  logic [DATA_W-1:0]         dma_data;
  logic                      dma_valid;
  logic [0:0]                grant_id;
  logic                      arb_busy;

  int checks = 0;
  int passes = 0;

  bit auto_req  = 1'b0;
  bit eng_abort = 1'b0;

  int                strobe_cnt [NUM_REQ];
  int                start_cnt;
  int                dut_grants [$];
  logic [ADDR_W-1:0] dut_addrs  [$];

  bit                m_ready [NUM_REQ];
  bit                m_pend  [NUM_REQ];
  logic [ADDR_W-1:0] m_addr  [NUM_REQ];
  logic [ADDR_W-1:0] m_dma_addr;
  int                m_grant;
  bit                m_start;
  bit                m_busy;
  bit                m_seen_low;
  int                model_grants [$];

  dma_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK               (clk),
    .RESET_N           (rst_n),
    .REQ_RD_ADDR       (req_addr),
    .REQ_START         (req_start),
    .REQ_READY         (req_ready),
    .REQ_RD_DATA       (req_data),
    .REQ_RD_DATA_VALID (req_valid),
    .DMA_RD_ADDR       (dma_addr),
    .DMA_START         (dma_start),
    .DMA_READY         (dma_ready),
    .DMA_RD_DATA       (dma_data),
    .DMA_RD_DATA_VALID (dma_valid),
    .GRANT_ID          (grant_id),
    .ARB_BUSY          (arb_busy)
  );

  // Free-running DMA clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
  endtask

  task automatic failTimeout(input string name);
    checks++;
    $display("[TB] FAIL %s: actual=timeout required=event", name);
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_ready[i] = 1'b1;
      m_pend[i]  = 1'b0;
      m_addr[i]  = '0;
    end
    m_dma_addr = '0;
    m_grant    = 0;
    m_start    = 1'b0;
    m_busy     = 1'b0;
    m_seen_low = 1'b0;
  endfunction

  function automatic int modelPick();
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (m_pend[(m_grant + k) % NUM_REQ]) return (m_grant + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Advance the burst-level model by one clock using this cycle's inputs.
  function automatic void modelStep();
    int pick;
    bit done;
    bit went_low;
    done     = m_busy && !m_start && m_seen_low && dma_ready;
    went_low = m_busy && !m_start && !m_seen_low && !dma_ready;
    pick     = (!m_busy && dma_ready) ? modelPick() : -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_start[i] && m_ready[i]) begin
        m_pend[i]  = 1'b1;
        m_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        m_ready[i] = 1'b0;
      end
    end
    if (done) begin
      m_pend[m_grant]  = 1'b0;
      m_ready[m_grant] = 1'b1;
      m_busy           = 1'b0;
    end
    if (m_start) m_start = 1'b0;
    if (went_low) m_seen_low = 1'b1;
    if (pick >= 0) begin
      m_grant    = pick;
      m_dma_addr = m_addr[pick];
      m_start    = 1'b1;
      m_busy     = 1'b1;
      m_seen_low = 1'b0;
      model_grants.push_back(pick);
    end
  endfunction

  task automatic compareAll();
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      exp_ready[i] = m_ready[i];
      exp_valid[i] = dma_valid && m_busy && !m_start && (m_grant == i);
    end
    checkOutput("REQ_READY", 64'(req_ready), 64'(exp_ready));
    checkOutput("REQ_RD_DATA_VALID", 64'(req_valid), 64'(exp_valid));
    checkOutput("REQ_RD_DATA", 64'(req_data), 64'(dma_data));
    checkOutput("DMA_START", 64'(dma_start), 64'(m_start));
    checkOutput("DMA_RD_ADDR", 64'(dma_addr), 64'(m_dma_addr));
    checkOutput("GRANT_ID", 64'(grant_id), 64'(m_grant));
    checkOutput("ARB_BUSY", 64'(arb_busy), 64'(m_busy));
  endtask

  // Per-cycle compare against the model, plus DUT event bookkeeping.
  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        modelReset();
        compareAll();
      end else begin
        compareAll();
        for (int i = 0; i < NUM_REQ; i++) if (req_valid[i]) strobe_cnt[i]++;
        if (dma_start) begin
          start_cnt++;
          dut_grants.push_back(int'(grant_id));
          dut_addrs.push_back(dma_addr);
        end
        modelStep();
      end
    end
  end

  // DMA engine responder: on each start, go busy and stream BURST_LEN beats.
  initial begin
    dma_ready = 1'b1;
    dma_valid = 1'b0;
    dma_data  = '0;
    forever begin
      @(negedge clk);
      if (dma_start && rst_n && !eng_abort) begin
        @(posedge clk); #1;
        dma_ready = 1'b0;
        for (int k = 0; k < BURST_LEN; k++) begin
          if (eng_abort) break;
          dma_valid = 1'b1;
          dma_data  = $urandom;
          @(posedge clk); #1;
        end
        dma_valid = 1'b0;
        dma_ready = 1'b1;
      end
    end
  end

  // Greedy requesters: whenever a port is ready, start a new burst on it.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_req) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_start[i]                  = req_ready[i];
          req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    @(posedge clk); #1;
    req_addr  = {a1, a0};
    req_start = mask;
    @(posedge clk); #1;
    req_start = '0;
  endtask

  task automatic waitStart(input string name);
    bit found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (dma_start) found = 1'b1;
    end
    if (!found) failTimeout(name);
  endtask

  task automatic waitIdle(input string name);
    bit found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (req_ready == '1 && !arb_busy) found = 1'b1;
    end
    if (!found) failTimeout(name);
  endtask

  task automatic clearCounters();
    for (int i = 0; i < NUM_REQ; i++) strobe_cnt[i] = 0;
    start_cnt = 0;
    dut_grants.delete();
    dut_addrs.delete();
  endtask

  // Directed scenarios.
  initial begin
    bit found;
    req_start = '0;
    req_addr  = '0;
    clearCounters();

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 64'(req_ready), 64'h3);
    checkOutput("rst_start", 64'(dma_start), 64'h0);
    checkOutput("rst_addr", 64'(dma_addr), 64'h0);
    checkOutput("rst_grant", 64'(grant_id), 64'h0);
    checkOutput("rst_busy", 64'(arb_busy), 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] single request from requester 0");
    #1 clearCounters();
    @(posedge clk); #1;
    req_addr[ADDR_W-1:0] = 30'h1000_0000;
    req_start            = 2'b01;
    @(posedge clk); #1;
    req_start = '0;
    @(negedge clk);
    checkOutput("single_c1_start", 64'(dma_start), 64'h0);
    checkOutput("single_c1_ready0", 64'(req_ready[0]), 64'h0);
    @(negedge clk);
    checkOutput("single_c2_start", 64'(dma_start), 64'h1);
    checkOutput("single_c2_addr", 64'(dma_addr), 64'h1000_0000);
    checkOutput("single_c2_grant", 64'(grant_id), 64'h0);
    checkOutput("single_c2_busy", 64'(arb_busy), 64'h1);
    @(negedge clk);
    checkOutput("single_c3_start", 64'(dma_start), 64'h0);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (dma_ready && arb_busy) found = 1'b1;
    end
    if (!found) failTimeout("single_done");
    checkOutput("single_ready_at_done", 64'(req_ready[0]), 64'h0);
    @(negedge clk);
    checkOutput("single_ready_after_done", 64'(req_ready[0]), 64'h1);
    checkOutput("single_busy_after_done", 64'(arb_busy), 64'h0);
    #1;
    checkOutput("single_strobes0", 64'(strobe_cnt[0]), 64'd8);
    checkOutput("single_strobes1", 64'(strobe_cnt[1]), 64'd0);

    $display("[TB] stray data while idle");
    @(posedge clk); #1;
    dma_valid = 1'b1;
    dma_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("stray_valid", 64'(req_valid), 64'h0);
    end
    @(posedge clk); #1;
    dma_valid = 1'b0;

    $display("[TB] start pulse while not ready");
    clearCounters();
    applyStimulus(2'b10, 30'h0, 30'h0ABC_DEF0);
    waitStart("illegal_first_start");
    checkOutput("illegal_ready1_low", 64'(req_ready[1]), 64'h0);
    @(posedge clk); #1;
    req_addr[2*ADDR_W-1:ADDR_W] = 30'h3FFF_0000;
    req_start                   = 2'b10;
    @(posedge clk); #1;
    req_start = '0;
    waitIdle("illegal_idle");
    repeat (6) @(negedge clk);
    #1;
    checkOutput("illegal_bursts", 64'(start_cnt), 64'd1);
    checkOutput("illegal_addr_held", 64'(dma_addr), 64'h0ABC_DEF0);
    checkOutput("illegal_grant", 64'(grant_id), 64'h1);

    $display("[TB] simultaneous requests");
    clearCounters();
    applyStimulus(2'b11, 30'h0000_1234, 30'h0200_5678);
    waitStart("sim_first_start");
    waitStart("sim_second_start");
    #1;
    checkOutput("sim_burst0_strobes0", 64'(strobe_cnt[0]), 64'd8);
    checkOutput("sim_burst0_strobes1", 64'(strobe_cnt[1]), 64'd0);
    waitIdle("sim_idle");
    #1;
    checkOutput("sim_grant_count", 64'(dut_grants.size()), 64'd2);
    if (dut_grants.size() == 2) begin
      checkOutput("sim_grant0", 64'(dut_grants[0]), 64'd0);
      checkOutput("sim_grant1", 64'(dut_grants[1]), 64'd1);
      checkOutput("sim_addr0", 64'(dut_addrs[0]), 64'h0000_1234);
      checkOutput("sim_addr1", 64'(dut_addrs[1]), 64'h0200_5678);
    end
    checkOutput("sim_model_grant0", 64'(model_grants[model_grants.size()-2]), 64'd0);
    checkOutput("sim_model_grant1", 64'(model_grants[model_grants.size()-1]), 64'd1);

    $display("[TB] fairness under continuous requests");
    clearCounters();
    auto_req = 1'b1;
    found    = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk); #1;
      if (start_cnt >= 10) found = 1'b1;
    end
    if (!found) failTimeout("fair_ten_bursts");
    auto_req = 1'b0;
    @(posedge clk); #2;
    req_start = '0;
    waitIdle("fair_idle");
    #1;
    for (int k = 0; k < 10 && k < dut_grants.size(); k++) begin
      checkOutput($sformatf("fair_grant%0d", k), 64'(dut_grants[k]), 64'(k % 2));
    end

    $display("[TB] reset during a burst");
    clearCounters();
    applyStimulus(2'b01, 30'h2222_0000, 30'h0);
    waitStart("rst_burst_start");
    repeat (4) @(negedge clk);
    checkOutput("rst_mid_busy", 64'(arb_busy), 64'h1);
    #2;
    rst_n     = 1'b0;
    eng_abort = 1'b1;
    #1;
    checkOutput("rst_async_ready", 64'(req_ready), 64'h3);
    checkOutput("rst_async_start", 64'(dma_start), 64'h0);
    checkOutput("rst_async_addr", 64'(dma_addr), 64'h0);
    checkOutput("rst_async_grant", 64'(grant_id), 64'h0);
    checkOutput("rst_async_busy", 64'(arb_busy), 64'h0);
    checkOutput("rst_async_valid", 64'(req_valid), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    eng_abort = 1'b0;
    clearCounters();
    applyStimulus(2'b10, 30'h0, 30'h0555_5555);
    waitStart("post_rst_start");
    waitIdle("post_rst_idle");
    #1;
    checkOutput("post_rst_bursts", 64'(start_cnt), 64'd1);
    if (dut_grants.size() == 1) begin
      checkOutput("post_rst_grant", 64'(dut_grants[0]), 64'd1);
      checkOutput("post_rst_addr", 64'(dut_addrs[0]), 64'h0555_5555);
    end
    checkOutput("post_rst_strobes1", 64'(strobe_cnt[1]), 64'd8);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
